// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the parametrised register bank.
package reg_bank_pkg;

  typedef enum logic [1:0] {
    RW  = 2'd0,
    RO  = 2'd1,
    W1C = 2'd2
  } reg_access_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bank_state_e;

  // be_merge works on the widest supported register; callers size-cast in and out.
  localparam int BE_MAX_DW    = 256;
  localparam int BE_MAX_BYTES = BE_MAX_DW / 8;

  function automatic logic [BE_MAX_DW-1:0] be_merge(
    input logic [BE_MAX_DW-1:0]    oldVal,
    input logic [BE_MAX_DW-1:0]    newVal,
    input logic [BE_MAX_BYTES-1:0] be
  );
    logic [BE_MAX_DW-1:0] merged;
    merged = oldVal;
    for (int k = 0; k < BE_MAX_BYTES; k++) begin
      if (be[k]) merged[k*8 +: 8] = newVal[k*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Request/response bus between the bus bridge (master) and the register bank (slave).
interface reg_bank_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reg_bank_cell.sv
// One register of the bank: byte-enabled bus writes, RW/RO/W1C behaviour,
// hardware set strobes and an optional asynchronous reset.
module reg_bank_cell
  import reg_bank_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0,
  parameter bit                    RESET_EN   = 1'b1,
  parameter reg_access_e           MODE       = RW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wrEn,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [DATA_WIDTH-1:0]   hwSet,
  output logic [DATA_WIDTH-1:0]   q
);

  logic [DATA_WIDTH-1:0] busMerged;
  logic [DATA_WIDTH-1:0] busClear;
  logic [DATA_WIDTH-1:0] nextQ;

  assign busMerged = DATA_WIDTH'(be_merge(BE_MAX_DW'(q), BE_MAX_DW'(wdata), BE_MAX_BYTES'(be)));
  assign busClear  = wrEn ? DATA_WIDTH'(be_merge('0, BE_MAX_DW'(wdata), BE_MAX_BYTES'(be)))
                          : '0;

  // W1C applies the clear first so a simultaneous hardware set wins.
  always_comb begin
    nextQ = q;
    case (MODE)
      RW:      if (wrEn) nextQ = busMerged;
      W1C:     nextQ = (q & ~busClear) | hwSet;
      default: nextQ = q;
    endcase
  end

  generate
    if (RESET_EN) begin : gReset
      always_ff @(posedge clk or posedge reset) begin
        if (reset) q <= RESET_VAL;
        else       q <= nextQ;
      end
    end else begin : gNoReset
      logic unusedReset;
      assign unusedReset = reset;
      always_ff @(posedge clk) begin
        q <= nextQ;
      end
    end
  endgenerate

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank controller: single-outstanding request/response FSM,
// address decode, read mux, error response and per-register write pulses.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter int                                    NUM_REGS   = 8,
  parameter int                                    ADDR_WIDTH = 3,
  parameter int                                    DATA_WIDTH = 32,
  parameter logic [NUM_REGS-1:0][DATA_WIDTH-1:0]   RESET_VAL  = '0,
  parameter logic [NUM_REGS-1:0]                   RESET_EN   = '1,
  // Each entry holds a reg_access_e encoding.
  parameter logic [NUM_REGS-1:0][1:0]              ACCESS     = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  reg_bank_if.slave                      bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_set,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  bank_state_e           state, nextState;
  logic                  accept;
  logic                  addrOk;
  logic                  roHit;
  logic [NUM_REGS-1:0]   regHit;
  logic [NUM_REGS-1:0]   wrEn;
  logic [DATA_WIDTH-1:0] rdMux;
  logic [DATA_WIDTH-1:0] regQ [NUM_REGS];

  assign accept = (state == IDLE) && bus.req_valid;
  assign addrOk = 32'(bus.req_addr) < 32'(NUM_REGS);

  always_comb begin
    regHit = '0;
    roHit  = 1'b0;
    rdMux  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.req_addr == ADDR_WIDTH'(i)) begin
        regHit[i] = 1'b1;
        roHit     = (ACCESS[i] == RO);
        rdMux     = (ACCESS[i] == RO) ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regQ[i];
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : gCell
      assign wrEn[i] = accept && bus.req_write && regHit[i] && (ACCESS[i] != RO);

      reg_bank_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .RESET_VAL  (RESET_VAL[i]),
        .RESET_EN   (RESET_EN[i]),
        .MODE       (reg_access_e'(ACCESS[i]))
      ) uCell (
        .clk   (clk),
        .reset (reset),
        .wrEn  (wrEn[i]),
        .wdata (bus.req_wdata),
        .be    (bus.req_be),
        .hwSet (hw_set[i*DATA_WIDTH +: DATA_WIDTH]),
        .q     (regQ[i])
      );

      assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regQ[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState     = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) nextState = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Response fields are captured once at acceptance and held through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      wr_pulse      <= '0;
    end else begin
      wr_pulse <= wrEn;
      if (accept) begin
        bus.rsp_err   <= !addrOk || (bus.req_write && roHit);
        bus.rsp_rdata <= (addrOk && !bus.req_write) ? rdMux : '0;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl: directed vector table, reset-in-RESP
// sequence and randomized transactions against a register-array model.
module tb_reg_bank_ctrl;
  import reg_bank_pkg::*;

  localparam int NR = 8;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam logic [NR-1:0][DW-1:0] RST_VAL =
    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h1, 32'h0};
  localparam logic [NR-1:0] RST_EN = 8'b1001_1111;
  localparam logic [NR-1:0][1:0] ACC =
    {2'(RW), 2'(RW), 2'(RW), 2'(RW), 2'(RO), 2'(W1C), 2'(RW), 2'(RW)};

  typedef struct {
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    be;
    logic [DW-1:0] set2;
    logic [DW-1:0] in3;
    int            stall;
    logic [DW-1:0] expRd;
    bit            expErr;
    logic [NR-1:0] expPulse;
    int            chkReg;
    logic [DW-1:0] expReg;
  } vec_t;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR*DW-1:0]  regsOut;
  logic [NR*DW-1:0]  hwIn = '0;
  logic [NR*DW-1:0]  hwSet = '0;
  logic [NR-1:0]     wrPulse;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] mdl   [NR];
  logic [DW-1:0] known [NR];
  vec_t          vecs  [$];

  reg_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_bank_ctrl #(
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_VAL  (RST_VAL),
    .RESET_EN   (RST_EN),
    .ACCESS     (ACC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .regs_out (regsOut),
    .hw_in    (hwIn),
    .hw_set   (hwSet),
    .wr_pulse (wrPulse)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] beMask(input logic [3:0] be);
    logic [DW-1:0] m;
    for (int k = 0; k < 4; k++) m[k*8 +: 8] = be[k] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // Reset-enabled registers return to their reset value; RO contents are not tracked.
  function automatic void modelReset();
    for (int i = 0; i < NR; i++) begin
      if (RST_EN[i]) begin
        mdl[i]   = RST_VAL[i];
        known[i] = '1;
      end
    end
    known[3] = '0;
  endfunction

  function automatic void modelTxn(input bit wr, input int addr, input logic [DW-1:0] wdata,
                                   input logic [3:0] be, input logic [DW-1:0] set2,
                                   input logic [DW-1:0] in3, output logic [DW-1:0] rd,
                                   output bit err, output logic [NR-1:0] pulse,
                                   output logic [DW-1:0] rdMask);
    logic [DW-1:0] m;
    m = beMask(be);
    rd = '0; err = 1'b0; pulse = '0; rdMask = '1;
    if (addr >= NR) err = 1'b1;
    else if (!wr) begin
      if (addr == 3) rd = in3;
      else begin
        rd     = mdl[addr];
        rdMask = known[addr];
      end
    end else if (addr == 3) err = 1'b1;
    else begin
      pulse[addr] = 1'b1;
      if (addr == 2) mdl[2] = mdl[2] & ~(wdata & m);
      else begin
        mdl[addr]   = (mdl[addr] & ~m) | (wdata & m);
        known[addr] = known[addr] | m;
      end
    end
    mdl[2] = mdl[2] | set2;
  endfunction

  task automatic checkRegs(input string tag);
    for (int i = 0; i < NR; i++) begin
      if (known[i] != '0)
        checkOutput($sformatf("%s regs_out[%0d]", tag, i),
                    64'(regsOut[i*DW +: DW] & known[i]), 64'(mdl[i] & known[i]));
    end
  endtask

  // Called #1 after a clock edge with the FSM idle; returns with the FSM idle again.
  task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input logic [3:0] be, input logic [DW-1:0] set2,
                               input logic [DW-1:0] in3, input int stall,
                               output logic [DW-1:0] gotRd, output logic gotErr,
                               output logic [NR-1:0] gotPulse);
    logic [DW-1:0] expRd, rdMask;
    bit            expErr;
    logic [NR-1:0] expPulse;
    checkOutput("req_ready idle", 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int i = 0; i < NR; i++) begin
      hwSet[i*DW +: DW] = (i == 2) ? set2 : DW'($urandom());
      hwIn[i*DW +: DW]  = (i == 3) ? in3  : DW'($urandom());
    end
    modelTxn(wr, int'(addr), wdata, be, set2, in3, expRd, expErr, expPulse, rdMask);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    hwSet = '0;
    gotRd = bus.rsp_rdata;
    gotErr = bus.rsp_err;
    gotPulse = wrPulse;
    checkOutput("rsp_valid after accept", 64'(bus.rsp_valid), 64'(1));
    checkOutput("req_ready in resp", 64'(bus.req_ready), 64'(0));
    checkOutput("rsp_err", 64'(bus.rsp_err), 64'(expErr));
    if (rdMask != '0)
      checkOutput("rsp_rdata", 64'(bus.rsp_rdata & rdMask), 64'(expRd & rdMask));
    checkOutput("wr_pulse", 64'(wrPulse), 64'(expPulse));
    checkRegs("accept");
    for (int c = 0; c < stall; c++) begin
      @(posedge clk); #1;
      checkOutput("stall rsp_valid", 64'(bus.rsp_valid), 64'(1));
      checkOutput("stall req_ready", 64'(bus.req_ready), 64'(0));
      checkOutput("stall rsp_err", 64'(bus.rsp_err), 64'(expErr));
      checkOutput("stall rsp_rdata", 64'(bus.rsp_rdata), 64'(gotRd));
      checkOutput("stall wr_pulse", 64'(wrPulse), 64'(0));
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    checkOutput("rsp_valid after done", 64'(bus.rsp_valid), 64'(0));
    checkOutput("req_ready after done", 64'(bus.req_ready), 64'(1));
    checkOutput("wr_pulse after done", 64'(wrPulse), 64'(0));
  endtask

  initial begin
    logic [DW-1:0] gotRd, expRd, rdMask;
    logic          gotErr;
    bit            expErr;
    logic [NR-1:0] gotPulse, expPulse;

    vecs.push_back('{1'b0, 4'd1,  32'h0,        4'h0, 32'h0, 32'h0,    0, 32'h1,        1'b0, 8'h00, 1, 32'h1});
    vecs.push_back('{1'b1, 4'd0,  32'hAABBCCDD, 4'h5, 32'h0, 32'h0,    0, 32'h0,        1'b0, 8'h01, 0, 32'h00BB00DD});
    vecs.push_back('{1'b0, 4'd7,  32'h0,        4'h0, 32'hF, 32'h0,    0, 32'h0,        1'b0, 8'h00, 2, 32'hF});
    vecs.push_back('{1'b1, 4'd2,  32'h3,        4'hF, 32'h1, 32'h0,    0, 32'h0,        1'b0, 8'h04, 2, 32'hD});
    vecs.push_back('{1'b1, 4'd2,  32'h4,        4'hF, 32'h0, 32'h0,    1, 32'h0,        1'b0, 8'h04, 2, 32'h9});
    vecs.push_back('{1'b1, 4'd3,  32'h55,       4'hF, 32'h0, 32'h1234, 0, 32'h0,        1'b1, 8'h00, 0, 32'h00BB00DD});
    vecs.push_back('{1'b0, 4'd3,  32'h0,        4'h0, 32'h0, 32'h1234, 0, 32'h1234,     1'b0, 8'h00, 0, 32'h00BB00DD});
    vecs.push_back('{1'b0, 4'd9,  32'h0,        4'h0, 32'h0, 32'h0,    5, 32'h0,        1'b1, 8'h00, 1, 32'h1});
    vecs.push_back('{1'b1, 4'd4,  32'hDEADBEEF, 4'h0, 32'h0, 32'h0,    0, 32'h0,        1'b0, 8'h10, 4, 32'h0});
    vecs.push_back('{1'b1, 4'd2,  32'hFFFFFFF1, 4'h1, 32'h0, 32'h0,    2, 32'h0,        1'b0, 8'h04, 2, 32'h8});
    vecs.push_back('{1'b0, 4'd0,  32'h0,        4'h0, 32'h0, 32'h0,    0, 32'h00BB00DD, 1'b0, 8'h00, 0, 32'h00BB00DD});
    vecs.push_back('{1'b1, 4'd15, 32'h12345678, 4'hF, 32'h0, 32'h0,    0, 32'h0,        1'b1, 8'h00, 1, 32'h1});
    vecs.push_back('{1'b1, 4'd1,  32'hCAFEF00D, 4'hA, 32'h0, 32'h0,    1, 32'h0,        1'b0, 8'h02, 1, 32'hCA00F001});
    vecs.push_back('{1'b0, 4'd1,  32'h0,        4'h0, 32'h0, 32'h0,    0, 32'hCA00F001, 1'b0, 8'h00, 1, 32'hCA00F001});

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin
      mdl[i]   = '0;
      known[i] = '0;
    end
    modelReset();

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'(1));
    checkOutput("reset rsp_valid", 64'(bus.rsp_valid), 64'(0));
    checkOutput("reset rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    checkOutput("reset rsp_err", 64'(bus.rsp_err), 64'(0));
    checkOutput("reset wr_pulse", 64'(wrPulse), 64'(0));
    checkRegs("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] directed vectors");
    for (int v = 0; v < vecs.size(); v++) begin
      applyStimulus(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be, vecs[v].set2,
                    vecs[v].in3, vecs[v].stall, gotRd, gotErr, gotPulse);
      checkOutput($sformatf("vec%0d rdata", v), 64'(gotRd), 64'(vecs[v].expRd));
      checkOutput($sformatf("vec%0d err", v), 64'(gotErr), 64'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d pulse", v), 64'(gotPulse), 64'(vecs[v].expPulse));
      checkOutput($sformatf("vec%0d reg%0d", v, vecs[v].chkReg),
                  64'(regsOut[vecs[v].chkReg*DW +: DW]), 64'(vecs[v].expReg));
    end

    $display("[TB] reset during response");
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'd5;
    bus.req_wdata = 32'h77;
    bus.req_be    = 4'hF;
    modelTxn(1'b1, 5, 32'h77, 4'hF, 32'h0, 32'h0, expRd, expErr, expPulse, rdMask);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checkOutput("rst seq rsp_valid", 64'(bus.rsp_valid), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst seq rsp_valid lost", 64'(bus.rsp_valid), 64'(0));
    checkOutput("rst seq req_ready", 64'(bus.req_ready), 64'(1));
    reset = 1'b0;
    modelReset();
    @(posedge clk); #1;
    checkOutput("rst seq reg5 kept", 64'(regsOut[5*DW +: DW]), 64'(32'h77));
    checkOutput("rst seq reg0 reset", 64'(regsOut[0 +: DW]), 64'(32'h0));
    checkOutput("rst seq reg1 reset", 64'(regsOut[1*DW +: DW]), 64'(32'h1));
    checkRegs("rst seq");

    $display("[TB] random transactions");
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)), DW'($urandom()),
                    4'($urandom()), ($urandom_range(0, 3) == 0) ? DW'($urandom()) : '0,
                    DW'($urandom()), int'($urandom_range(0, 2)), gotRd, gotErr, gotPulse);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
